seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, clocked successor of the processor's 16-bit combinational ALU.
- Adds a start/done handshake, registered outputs and flags, and iterative multi-cycle MUL and DIV.
- Sits in the execute stage; the stall logic holds the pipeline while Busy is high.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, width of the internal iteration counter.

Ports:
- Clk  input  1  rising-edge clock
- ResetN  input  1  asynchronous active-low reset
- Start  input  1  request; sampled only when Busy=0
- FirstOperand  input  WIDTH  operand A
- SeconedOperand  input  WIDTH  operand B / shift amount
- OP  input  9  one-hot opcode: bit0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 SHR, 6 SHL, 7 MUL, 8 DIV
- Result  output  WIDTH  low result / quotient
- ResultHi  output  WIDTH  MUL high half / DIV remainder; 0 for other ops
- ZeroFlag  output  1  Result==0
- CarryFlag  output  1  carry/borrow/overflow
- NegativeFlag  output  1  Result[WIDTH-1]
- DivByZero  output  1  last DIV had B==0
- IllegalOp  output  1  last OP was not one-hot
- Busy  output  1  MUL/DIV iteration in progress
- Done  output  1  one-cycle pulse: outputs updated

Behaviour:
- Reset (async, ResetN=0): state IDLE. All outputs and internal registers are 0. An in-flight MUL/DIV is abandoned and no Done is produced.
- States: IDLE, ITER.
- IDLE with Start=1 and a single-cycle op (bits 0-6):
  - Result, ResultHi, flags and Done=1 are registered on the same edge.
  - Latency is 1 edge; the state stays IDLE.
- IDLE with Start=1 and OP=MUL or DIV (B!=0):
  - Operands are latched and the counter is loaded with WIDTH. Go to ITER with Busy=1.
  - One shift-add (MUL) or restoring-subtract (DIV) step is performed per edge.
  - When the counter reaches 0, outputs are written, Done=1, Busy=0, and the state returns to IDLE.
  - Done is asserted exactly WIDTH edges after the accepting edge.
- DIV with B==0: single-cycle. Result=all ones, ResultHi=A, DivByZero=1, CarryFlag=0.
- Illegal OP (zero or more than one bit set): Done pulses after 1 edge with IllegalOp=1. Result, ResultHi and the Z/C/N flags hold their previous values.
- DivByZero and IllegalOp are rewritten on every Done.
- Start while Busy=1 is ignored; operands are not re-latched.
- Operand inputs may change freely during ITER.
- Start sampled in the cycle where Done=1 and Busy=0 is accepted (back-to-back issue).
- Outputs hold between Done pulses.
- Arithmetic:
  - ADD: C = carry out of bit WIDTH-1.
  - SUB: Result = A-B mod 2^WIDTH; C = borrow (A<B unsigned).
  - AND/OR/NOT: C = 0.
  - SHR (logical): for 1<=B<=WIDTH, C = A[B-1]. Result=0 if B>=WIDTH. B=0 passes A with C=0.
  - SHL: for 1<=B<=WIDTH, C = A[WIDTH-B]. Result=0 if B>=WIDTH. B=0 passes A with C=0.
  - MUL (unsigned): {ResultHi,Result} = A*B; C = |ResultHi.
  - DIV (unsigned): Result = A/B, ResultHi = A%B, C = 0.
- Flags: ZeroFlag and NegativeFlag are derived from Result only, for every legal op.

Test Plan:
- Reset, then WIDTH=16, Start with ADD A=FFFF B=0001 -> one edge later Done=1, Result=0000, Z=1, C=1, N=0; ResultHi=0.
- SUB A=0003 B=0005 -> Result=FFFE, C=1, N=1, Z=0. SHL A=8001 B=1 -> Result=0002, C=1. SHR A=0003 B=20 -> Result=0, C=0.
- MUL A=1234 B=0100 -> Busy for 16 edges, Done at edge 16, Result=3400, ResultHi=0012, C=1. A second Start pulsed during Busy is ignored: no extra Done appears.
- DIV A=0064 B=0007 -> Done after 16 edges, Result=000E, ResultHi=0002. DIV B=0 -> Done after 1 edge, Result=FFFF, ResultHi=A, DivByZero=1.
- OP=000000011 -> Done after 1 edge, IllegalOp=1, Result and flags unchanged from the previous op. Back-to-back: Start held through Done -> the next op is accepted with no idle cycle.
- ResetN pulled low at iteration 8 of a DIV -> immediate Busy=0, all outputs 0, no Done. After release, a new ADD completes normally.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with start/done handshake and iterative MUL/DIV.
//   Clk, ResetN        : rising-edge clock, asynchronous active-low reset
//   Start, OP          : request strobe and one-hot opcode
//                        (bit0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 SHR, 6 SHL, 7 MUL, 8 DIV)
//   FirstOperand (A), SeconedOperand (B / shift amount)
//   Result, ResultHi   : low result / quotient, MUL high half / DIV remainder
//   ZeroFlag, CarryFlag, NegativeFlag, DivByZero, IllegalOp : registered status
//   Busy, Done         : iteration in progress, one-cycle completion pulse
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [WIDTH-1:0] FirstOperand,
    input  logic [WIDTH-1:0] SeconedOperand,
    input  logic [8:0]       OP,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             ZeroFlag,
    output logic             CarryFlag,
    output logic             NegativeFlag,
    output logic             DivByZero,
    output logic             IllegalOp,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic {IDLE, ITER} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;   // multiplicand or divisor
    logic [WIDTH-1:0]   hi_reg;  // partial product high half or partial remainder
    logic [WIDTH-1:0]   lo_reg;  // multiplier shifting out / quotient shifting in
    logic               is_div;
    logic [CNT_W-1:0]   cnt;

    // Single-cycle datapath
    logic [WIDTH:0]     sum, diff, shr_ext, shl_ext;
    logic [WIDTH-1:0]   res, res_hi;
    logic               carry, div0;
    logic               legal, iterative;

    always_comb begin
        sum     = {1'b0, FirstOperand} + {1'b0, SeconedOperand};
        diff    = {1'b0, FirstOperand} - {1'b0, SeconedOperand};
        // One extra bit on the shifted-out side captures the last bit lost,
        // which is exactly the carry; large amounts naturally yield zero.
        shr_ext = {FirstOperand, 1'b0} >> SeconedOperand;
        shl_ext = {1'b0, FirstOperand} << SeconedOperand;
        res     = '0;
        res_hi  = '0;
        carry   = 1'b0;
        div0    = 1'b0;
        if (OP[0])      {carry, res} = sum;
        else if (OP[1]) {carry, res} = diff;
        else if (OP[2]) res = FirstOperand & SeconedOperand;
        else if (OP[3]) res = FirstOperand | SeconedOperand;
        else if (OP[4]) res = ~FirstOperand;
        else if (OP[5]) {res, carry} = shr_ext;
        else if (OP[6]) {carry, res} = shl_ext;
        else if (OP[8]) begin
            res    = '1;
            res_hi = FirstOperand;
            div0   = 1'b1;
        end
        legal     = $onehot(OP);
        iterative = OP[7] || (OP[8] && (SeconedOperand != '0));
    end

    // One iteration step of shift-add multiply / restoring divide
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + ({1'b0, a_reg} & {(WIDTH+1){lo_reg[0]}});
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, a_reg};
        if (is_div) begin
            step_hi = div_ge ? WIDTH'(div_shift - {1'b0, a_reg}) : div_shift[WIDTH-1:0];
            step_lo = {lo_reg[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state        <= IDLE;
            a_reg        <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            is_div       <= 1'b0;
            cnt          <= '0;
            Result       <= '0;
            ResultHi     <= '0;
            ZeroFlag     <= 1'b0;
            CarryFlag    <= 1'b0;
            NegativeFlag <= 1'b0;
            DivByZero    <= 1'b0;
            IllegalOp    <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (!legal) begin
                            // Datapath outputs and Z/C/N keep their old values
                            IllegalOp <= 1'b1;
                            DivByZero <= 1'b0;
                            Done      <= 1'b1;
                        end else if (iterative) begin
                            a_reg  <= OP[7] ? FirstOperand : SeconedOperand;
                            lo_reg <= OP[7] ? SeconedOperand : FirstOperand;
                            hi_reg <= '0;
                            is_div <= OP[8];
                            cnt    <= CNT_W'(WIDTH);
                            Busy   <= 1'b1;
                            state  <= ITER;
                        end else begin
                            Result       <= res;
                            ResultHi     <= res_hi;
                            ZeroFlag     <= (res == '0);
                            CarryFlag    <= carry;
                            NegativeFlag <= res[WIDTH-1];
                            DivByZero    <= div0;
                            IllegalOp    <= 1'b0;
                            Done         <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    hi_reg <= step_hi;
                    lo_reg <= step_lo;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        Result       <= step_lo;
                        ResultHi     <= step_hi;
                        ZeroFlag     <= (step_lo == '0);
                        CarryFlag    <= !is_div && (step_hi != '0);
                        NegativeFlag <= step_lo[WIDTH-1];
                        DivByZero    <= 1'b0;
                        IllegalOp    <= 1'b0;
                        Busy         <= 1'b0;
                        Done         <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    localparam int W = 16;
    localparam logic [8:0] OP_ADD = 9'h001, OP_SUB = 9'h002, OP_NOT = 9'h010,
                           OP_SHR = 9'h020, OP_SHL = 9'h040, OP_MUL = 9'h080,
                           OP_DIV = 9'h100, OP_BAD = 9'h003;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic [8:0]   op;
    logic [W-1:0] result, result_hi;
    logic         zf, cf, nf, dbz, ill, busy, done;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.WIDTH(W)) dut (
        .Clk(clk), .ResetN(rst_n), .Start(start),
        .FirstOperand(a), .SeconedOperand(b), .OP(op),
        .Result(result), .ResultHi(result_hi),
        .ZeroFlag(zf), .CarryFlag(cf), .NegativeFlag(nf),
        .DivByZero(dbz), .IllegalOp(ill), .Busy(busy), .Done(done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; sampling happens 1ns after it.
    task automatic step();
        @(posedge clk); #1;
    endtask

    // Issue one request and count rising edges (including the accepting one)
    // until Done is seen; single-cycle ops give 1, MUL/DIV give W+1.
    // The bound of 40 makes a missing Done show up as a wrong latency.
    task automatic run_op(input logic [8:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, output int lat);
        op = o; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        step(); step();
        checks++;
        if ({result, result_hi, zf, cf, nf, dbz, ill, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%h flags=%b exp=0", result, result_hi,
                     {zf, cf, nf, dbz, ill, busy, done});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int lat;
        run_op(OP_ADD, 16'hFFFF, 16'h0001, lat);
        checks++;
        if (lat !== 1 || result !== 16'h0000 || result_hi !== 16'h0000 || {zf, cf, nf} !== 3'b110) begin
            failures++;
            $display("FAIL add_wrap got lat=%0d r=%h hi=%h zcn=%b exp lat=1 r=0000 hi=0000 zcn=110",
                     lat, result, result_hi, {zf, cf, nf});
        end
        step();
        checks++;
        if (done !== 1'b0 || result !== 16'h0000) begin
            failures++;
            $display("FAIL done_pulse got done=%b r=%h exp done=0 r=0000", done, result);
        end
        run_op(OP_SUB, 16'h0003, 16'h0005, lat);
        checks++;
        if (lat !== 1 || result !== 16'hFFFE || {zf, cf, nf} !== 3'b011) begin
            failures++;
            $display("FAIL sub_borrow got lat=%0d r=%h zcn=%b exp lat=1 r=fffe zcn=011",
                     lat, result, {zf, cf, nf});
        end
        run_op(OP_SHL, 16'h8001, 16'd1, lat);
        checks++;
        if (result !== 16'h0002 || {zf, cf, nf} !== 3'b010) begin
            failures++;
            $display("FAIL shl_1 got r=%h zcn=%b exp r=0002 zcn=010", result, {zf, cf, nf});
        end
        run_op(OP_SHR, 16'h0003, 16'h0020, lat);
        checks++;
        if (result !== 16'h0000 || {zf, cf, nf} !== 3'b100) begin
            failures++;
            $display("FAIL shr_big got r=%h zcn=%b exp r=0000 zcn=100", result, {zf, cf, nf});
        end
        run_op(OP_SHR, 16'h8000, 16'd16, lat);
        checks++;
        if (result !== 16'h0000 || cf !== 1'b1) begin
            failures++;
            $display("FAIL shr_width got r=%h c=%b exp r=0000 c=1", result, cf);
        end
        run_op(OP_SHL, 16'h0001, 16'd16, lat);
        checks++;
        if (result !== 16'h0000 || cf !== 1'b1) begin
            failures++;
            $display("FAIL shl_width got r=%h c=%b exp r=0000 c=1", result, cf);
        end
        run_op(OP_SHR, 16'hA5A5, 16'd0, lat);
        checks++;
        if (result !== 16'hA5A5 || {zf, cf, nf} !== 3'b001) begin
            failures++;
            $display("FAIL shr_zero got r=%h zcn=%b exp r=a5a5 zcn=001", result, {zf, cf, nf});
        end
        run_op(OP_NOT, 16'h00FF, 16'h1234, lat);
        checks++;
        if (result !== 16'hFF00 || {zf, cf, nf} !== 3'b001) begin
            failures++;
            $display("FAIL not got r=%h zcn=%b exp r=ff00 zcn=001", result, {zf, cf, nf});
        end
    endtask

    task automatic test_mul();
        int lat;
        int extra;
        op = OP_MUL; a = 16'h1234; b = 16'h0100; start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL mul_busy got busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        while (!done && lat < 40) begin
            // A Start with new operands mid-iteration must be ignored
            if (lat == 5) begin
                op = OP_ADD; a = 16'h0001; b = 16'h0001; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            lat++;
        end
        checks++;
        if (lat !== W + 1 || busy !== 1'b0 || result !== 16'h3400 || result_hi !== 16'h0012 || cf !== 1'b1) begin
            failures++;
            $display("FAIL mul got lat=%0d busy=%b r=%h hi=%h c=%b exp lat=17 busy=0 r=3400 hi=0012 c=1",
                     lat, busy, result, result_hi, cf);
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) extra++;
        end
        checks++;
        if (extra !== 0 || result !== 16'h3400) begin
            failures++;
            $display("FAIL mul_ignored_start got extra_done=%0d r=%h exp 0 r=3400", extra, result);
        end
    endtask

    task automatic test_div();
        int lat;
        run_op(OP_DIV, 16'h0064, 16'h0007, lat);
        checks++;
        if (lat !== W + 1 || result !== 16'h000E || result_hi !== 16'h0002 || {zf, cf, nf, dbz} !== 4'b0000) begin
            failures++;
            $display("FAIL div got lat=%0d r=%h hi=%h zcnd=%b exp lat=17 r=000e hi=0002 zcnd=0000",
                     lat, result, result_hi, {zf, cf, nf, dbz});
        end
        run_op(OP_DIV, 16'h1234, 16'h0000, lat);
        checks++;
        if (lat !== 1 || result !== 16'hFFFF || result_hi !== 16'h1234 || {zf, cf, nf, dbz} !== 4'b0011) begin
            failures++;
            $display("FAIL div_zero got lat=%0d r=%h hi=%h zcnd=%b exp lat=1 r=ffff hi=1234 zcnd=0011",
                     lat, result, result_hi, {zf, cf, nf, dbz});
        end
    endtask

    task automatic test_illegal();
        int lat;
        run_op(OP_SUB, 16'h0003, 16'h0005, lat);
        run_op(OP_BAD, 16'h0001, 16'h0001, lat);
        checks++;
        if (lat !== 1 || ill !== 1'b1 || dbz !== 1'b0 || result !== 16'hFFFE || {zf, cf, nf} !== 3'b011) begin
            failures++;
            $display("FAIL illegal got lat=%0d ill=%b dbz=%b r=%h zcn=%b exp lat=1 ill=1 dbz=0 r=fffe zcn=011",
                     lat, ill, dbz, result, {zf, cf, nf});
        end
        run_op(9'h000, 16'h0001, 16'h0001, lat);
        checks++;
        if (lat !== 1 || ill !== 1'b1 || result !== 16'hFFFE) begin
            failures++;
            $display("FAIL illegal_zero got lat=%0d ill=%b r=%h exp lat=1 ill=1 r=fffe", lat, ill, result);
        end
        run_op(OP_ADD, 16'h0002, 16'h0003, lat);
        checks++;
        if (ill !== 1'b0 || result !== 16'h0005) begin
            failures++;
            $display("FAIL illegal_clear got ill=%b r=%h exp ill=0 r=0005", ill, result);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        op = OP_MUL; a = 16'h0003; b = 16'h0005; start = 1'b1;
        step();
        // Keep Start high with an ADD queued behind the running MUL
        op = OP_ADD; a = 16'h0010; b = 16'h0020;
        lat = 1;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== W + 1 || result !== 16'h000F || result_hi !== 16'h0000 || cf !== 1'b0) begin
            failures++;
            $display("FAIL b2b_mul got lat=%0d r=%h hi=%h c=%b exp lat=17 r=000f hi=0000 c=0",
                     lat, result, result_hi, cf);
        end
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 16'h0030) begin
            failures++;
            $display("FAIL b2b_add got done=%b r=%h exp done=1 r=0030", done, result);
        end
        step();
    endtask

    task automatic test_reset_mid_div();
        int lat;
        int seen;
        op = OP_DIV; a = 16'h0064; b = 16'h0007; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({result, result_hi, zf, cf, nf, dbz, ill, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_mid_div got r=%h hi=%h flags=%b exp all 0", result, result_hi,
                     {zf, cf, nf, dbz, ill, busy, done});
        end
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_abandon got done_or_busy_cycles=%0d exp 0", seen);
        end
        run_op(OP_ADD, 16'h1111, 16'h2222, lat);
        checks++;
        if (lat !== 1 || result !== 16'h3333 || {zf, cf, nf} !== 3'b000) begin
            failures++;
            $display("FAIL post_reset_add got lat=%0d r=%h zcn=%b exp lat=1 r=3333 zcn=000",
                     lat, result, {zf, cf, nf});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mul();
        test_div();
        test_illegal();
        test_back_to_back();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
